// File: rtl/shift_add_mul.sv
// shift_add_mul: iterative shift-and-add multiplier with a valid/ready handshake
// on both sides.
//
// Operation
//   - One operand pair is accepted while idle.
//   - Operands are reduced to magnitudes, and the product is built by one add
//     per multiplier bit, one bit per cycle.
//   - The loop stops as soon as the remaining multiplier bits are all zero.
//   - The result is sign-corrected when the accumulator is unloaded.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   in_valid      operand pair on x/y/signed_mode is valid
//   in_ready      block is idle and can accept operands
//   x, y          multiplicand / multiplier, DATAWIDTH bits each
//   signed_mode   1 = two's-complement operands and result, 0 = unsigned
//   out_valid     result is valid (held until out_ready)
//   out_ready     consumer accepts the result
//   result        registered 2*DATAWIDTH-bit product
//   busy          an operation is in progress or waiting to be consumed

module shift_add_mul #(
    parameter int unsigned DATAWIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATAWIDTH-1:0]   x,
    input  logic [DATAWIDTH-1:0]   y,
    input  logic                   signed_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*DATAWIDTH-1:0] result,
    output logic                   busy
);

    localparam int unsigned PW = 2 * DATAWIDTH;
    localparam int unsigned CW = $clog2(DATAWIDTH + 1);
    localparam logic [CW-1:0] CntLast = CW'(DATAWIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [PW-1:0]          p_q, p_d;
    logic [PW-1:0]          t_q, t_d;
    logic [PW-1:0]          result_q, result_d;
    logic [DATAWIDTH-1:0]   m_q, m_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   neg_q, neg_d;

    logic [DATAWIDTH-1:0]   x_mag, y_mag;
    logic [PW-1:0]          p_sum;
    logic [DATAWIDTH-1:0]   m_shift;
    logic [CW-1:0]          cnt_inc;
    logic                   calc_last;

    // Negating the most negative value wraps back to 100..0, which is exactly
    // its magnitude when read as unsigned.
    always_comb begin
        x_mag = x;
        y_mag = y;
        if (signed_mode && x[DATAWIDTH-1]) x_mag = ~x + DATAWIDTH'(1);
        if (signed_mode && y[DATAWIDTH-1]) y_mag = ~y + DATAWIDTH'(1);
    end

    always_comb begin
        p_sum     = m_q[0] ? (p_q + t_q) : p_q;
        m_shift   = m_q >> 1;
        cnt_inc   = cnt_q + CW'(1);
        // Exit once no set multiplier bits remain; the counter guards the full-width case.
        calc_last = (m_shift == '0) || (cnt_inc == CntLast);
    end

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        t_d      = t_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    p_d     = '0;
                    t_d     = PW'(x_mag);
                    m_d     = y_mag;
                    cnt_d   = '0;
                    neg_d   = signed_mode & (x[DATAWIDTH-1] ^ y[DATAWIDTH-1]);
                    state_d = StCalc;
                end
            end
            StCalc: begin
                p_d   = p_sum;
                t_d   = t_q << 1;
                m_d   = m_shift;
                cnt_d = cnt_inc;
                if (calc_last) begin
                    result_d = neg_q ? (~p_sum + PW'(1)) : p_sum;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            p_q      <= '0;
            t_q      <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            t_q      <= t_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign result    = result_q;

endmodule

// File: tb/tb_shift_add_mul.sv
// tb_shift_add_mul: scoreboard bench for shift_add_mul (DATAWIDTH = 8).
//
// Structure
//   - The driver pushes the expected result and latency when an operand pair
//     is accepted.
//   - The monitor checks latency and result when out_valid rises, and pops the
//     entry on the output handshake.
//
// Timing
//   - Inputs change 1 time unit after the rising edge.
//   - The monitor samples on the falling edge.

module tb_shift_add_mul;

    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic           signed_mode;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] result;
    logic           busy;

    shift_add_mul #(.DATAWIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .y          (y),
        .signed_mode(signed_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] res;
        int unsigned lat;
        int unsigned acc;
    } txn_t;

    txn_t        sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b,
                                             input logic m);
        int ia, ib;
        logic [31:0] p;
        ia = m ? int'($signed(a)) : int'(a);
        ib = m ? int'($signed(b)) : int'(b);
        p  = ia * ib;
        return p[15:0];
    endfunction

    // Latency from the accept cycle to out_valid is the iteration count plus one.
    function automatic int unsigned ref_lat(input logic [7:0] b, input logic m);
        int ib;
        int unsigned c;
        ib = m ? int'($signed(b)) : int'(b);
        if (ib < 0) ib = -ib;
        c = 1;
        for (int i = 0; i < 8; i++) if (ib[i]) c = i + 1;
        return c + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair until accepted, then record what must come out.
    task automatic send(input logic [7:0] xi, input logic [7:0] yi, input logic mi,
                        input logic [15:0] er, input int unsigned el);
        int unsigned budget = 0;
        in_valid    = 1'b1;
        x           = xi;
        y           = yi;
        signed_mode = mi;
        while (!in_ready && budget < 50) begin
            tick();
            budget++;
        end
        if (!in_ready) begin
            check_eq("accept_timeout", in_ready, 1'b1);
            in_valid = 1'b0;
            return;
        end
        sb_q.push_back('{er, el, cyc});
        tick();
        in_valid = 1'b0;
        x        = 8'($urandom);
        y        = 8'($urandom);
    endtask

    task automatic drain();
        int unsigned budget = 0;
        while (sb_q.size() != 0 && budget < 100) begin
            tick();
            budget++;
        end
        check_eq("drain", sb_q.size(), 0);
    endtask

    // Monitor
    initial begin
        bit ov_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ov_seen = 1'b0;
            end else if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_out_valid", out_valid, 1'b0);
                end else begin
                    if (!ov_seen) begin
                        ov_seen = 1'b1;
                        check_eq("latency", cyc - sb_q[0].acc, sb_q[0].lat);
                        check_eq("result", result, sb_q[0].res);
                    end
                    if (out_ready) begin
                        void'(sb_q.pop_front());
                        ov_seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  xi, yi;
        logic        mi;
        int unsigned k, budget;

        rst         = 1'b1;
        in_valid    = 1'b0;
        x           = '0;
        y           = '0;
        signed_mode = 1'b0;
        out_ready   = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_result", result, 16'h0000);

        // Directed corner cases
        send(8'hFF, 8'hFF, 1'b0, 16'hFE01, 9);
        drain();
        send(8'hFD, 8'h05, 1'b1, 16'hFFF1, 4);
        drain();
        send(8'h80, 8'h80, 1'b1, 16'h4000, 9);
        drain();
        send(8'h7F, 8'h00, 1'b0, 16'h0000, 2);
        drain();
        send(8'h80, 8'hFF, 1'b1, 16'h0080, 2);
        drain();
        send(8'h05, 8'h81, 1'b0, 16'h0285, 9);
        drain();

        // Backpressure: hold DONE for 5 cycles with in_valid asserted
        out_ready = 1'b0;
        send(8'h0F, 8'h03, 1'b0, 16'h002D, 3);
        budget = 0;
        while (!out_valid && budget < 20) begin
            tick();
            budget++;
        end
        in_valid = 1'b1;
        x        = 8'hAA;
        y        = 8'h55;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_out_valid", out_valid, 1'b1);
            check_eq("bp_in_ready", in_ready, 1'b0);
            check_eq("bp_result", result, 16'h002D);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check_eq("bp_release_in_ready", in_ready, 1'b1);
        check_eq("bp_release_out_valid", out_valid, 1'b0);
        check_eq("bp_release_busy", busy, 1'b0);
        check_eq("bp_hold_result", result, 16'h002D);
        check_eq("bp_drained", sb_q.size(), 0);

        // Reset during the third CALC cycle aborts the operation
        send(8'd200, 8'd100, 1'b0, 16'd20000, 8);
        tick();
        tick();
        check_eq("abort_busy", busy, 1'b1);
        rst = 1'b1;
        sb_q.delete();
        tick();
        rst = 1'b0;
        check_eq("abort_in_ready", in_ready, 1'b1);
        check_eq("abort_busy_low", busy, 1'b0);
        check_eq("abort_out_valid", out_valid, 1'b0);
        check_eq("abort_result", result, 16'h0000);
        for (int i = 0; i < 12; i++) tick();
        send(8'd12, 8'd12, 1'b0, 16'd144, 5);
        drain();

        // Random back-to-back traffic; multiplier widths vary to exercise early exit
        for (int n = 0; n < 10000; n++) begin
            mi = 1'($urandom);
            xi = 8'($urandom);
            k  = $urandom_range(0, 8);
            yi = 8'($urandom);
            if (k < 8) begin
                yi = yi & 8'((1 << k) - 1);
                if (mi && $urandom_range(0, 1) == 1) yi = 8'(0) - yi;
            end
            send(xi, yi, mi, ref_prod(xi, yi, mi), ref_lat(yi, mi));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_add_mul.md
SHIFT_ADD_MUL -- requirements
Module: shift_add_mul

Interface
REQ-001 Parameter DATAWIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand pair on x/y/signed_mode valid.
REQ-005 in_ready  output  1  block can accept operands; high only in IDLE.
REQ-006 x  input  DATAWIDTH  multiplicand.
REQ-007 y  input  DATAWIDTH  multiplier.
REQ-008 signed_mode  input  1  1 = two's-complement operands/result, 0 = unsigned.
REQ-009 out_valid  output  1  result valid; high only in DONE.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  2*DATAWIDTH  registered product.
REQ-012 busy  output  1  high in CALC or DONE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-014 Accept occurs in a cycle with in_valid && in_ready; x, y, signed_mode SHALL be sampled only then, and the FSM SHALL enter CALC next cycle.
REQ-015 On accept: mode unsigned -> magnitudes are x, y; mode signed -> magnitudes are |x|, |y| as DATAWIDTH-bit unsigned (-2^(DATAWIDTH-1) maps to 2^(DATAWIDTH-1)); negate flag = sign(x) XOR sign(y) in signed mode, else 0.
REQ-016 On accept: accumulator P <= 0, T <= zero-extended |x| (2*DATAWIDTH bits), multiplier shift register <= |y|, iteration counter <= 0.
REQ-017 Each CALC cycle SHALL process one multiplier LSB: if 1, P <= P + T (mod 2^(2*DATAWIDTH)); T <= T << 1; shift register >> 1; counter +1.
REQ-018 Early termination: CALC SHALL exit to DONE after the cycle in which the shifted multiplier becomes zero or the counter reaches DATAWIDTH, whichever first.
REQ-019 CALC cycle count SHALL be (index of highest set bit of |y|) + 1, minimum 1 (y = 0 gives 1 cycle), maximum DATAWIDTH.
REQ-020 On CALC->DONE, result SHALL load the final P, two's-complement negated if negate flag = 1.
REQ-021 Latency: out_valid SHALL rise exactly (CALC cycle count + 1) cycles after the accept cycle.
REQ-022 In DONE, out_valid = 1 and result SHALL stay stable until out_valid && out_ready; FSM then returns to IDLE next cycle.
REQ-023 in_ready SHALL be 0 in CALC and DONE; in_valid there is ignored (no queuing); a new accept is possible no earlier than the cycle after the output handshake.
REQ-024 result SHALL hold its last value in IDLE and CALC until overwritten by the next REQ-020 load.
REQ-025 Unsigned product SHALL be exact (fits 2*DATAWIDTH bits); signed product SHALL be exact, including (-2^(N-1))^2 = 2^(2N-2).

Reset
REQ-026 With rst high at a clock edge: state <= IDLE, result <= 0, P/T/shift register/counter <= 0, negate flag <= 0; rst has priority over all other inputs.
REQ-027 After reset: in_ready = 1, out_valid = 0, busy = 0.
REQ-028 Reset in CALC or DONE SHALL abort the operation; the aborted result SHALL never be presented.

Verification (DATAWIDTH = 8)
REQ-029 Unsigned x=255, y=255 -> 8 CALC cycles, out_valid 9 cycles after accept, result = 0xFE01.
REQ-030 Signed x=-3 (0xFD), y=5 -> 3 CALC cycles, out_valid 4 cycles after accept, result = 0xFFF1 (-15); signed x=-128, y=-128 -> result = 0x4000.
REQ-031 Unsigned x=0x7F, y=0 -> 1 CALC cycle, out_valid 2 cycles after accept, result = 0x0000.
REQ-032 Backpressure: out_ready low 5 cycles in DONE with in_valid high -> result, out_valid stable, in_ready = 0; out_ready high -> IDLE next cycle, in_ready = 1.
REQ-033 rst pulsed in 3rd CALC cycle of 200*100 -> next cycle IDLE, result = 0, out_valid never asserts for that operation; next op 12*12 -> result = 144.
REQ-034 Random self-check: >= 10,000 operand pairs, both modes, back-to-back accepts -> result matches reference product and latency matches REQ-021 on every transaction.
